// File: rtl/branch_resolve_stage.sv
// Branch resolution stage downstream of the ALU: latches Z and its flags, resolves
// conditional branches, and emits the next PC with a one-cycle pc_write strobe.
module branch_resolve_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              zero_flag,
    input  logic              carry_flag,
    input  logic [2:0]        br_type,
    input  logic [PC_W-1:0]   pc_cur,
    input  logic [IMM_W-1:0]  br_imm,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] alu_out,
    output logic [1:0]        flags_q,
    output logic              taken,
    output logic [PC_W-1:0]   pc_next,
    output logic              pc_write,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EVAL    = 2'd2
    } stateT;

    localparam logic [2:0] BR_EQ = 3'b001;
    localparam logic [2:0] BR_NE = 3'b010;
    localparam logic [2:0] BR_GT = 3'b011;
    localparam logic [2:0] BR_LT = 3'b100;

    stateT            state;
    stateT            stateNext;
    logic [2:0]       brTypeQ;
    logic [PC_W-1:0]  pcCurQ;
    logic [IMM_W-1:0] brImmQ;

    logic             brTaken;
    logic [PC_W-1:0]  immExt;
    logic [PC_W-1:0]  pcSeq;
    logic [PC_W-1:0]  pcTarget;
    logic             zeroQ;
    logic             carryQ;

    assign zeroQ  = flags_q[0];
    assign carryQ = flags_q[1];
    assign busy   = (state != IDLE);

    // NOTE: every variable written in always_comb gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = CAPTURE;
            CAPTURE: stateNext = EVAL;
            EVAL:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Decision uses the flags latched with alu_out, never the live ALU flags.
    always_comb begin
        brTaken = 1'b0;
        case (brTypeQ)
            BR_EQ:   brTaken = zeroQ;
            BR_NE:   brTaken = !zeroQ;
            BR_GT:   brTaken = !zeroQ && carryQ;
            BR_LT:   brTaken = !zeroQ && !carryQ;
            default: brTaken = 1'b0;
        endcase
    end

    assign immExt   = {{(PC_W-IMM_W){brImmQ[IMM_W-1]}}, brImmQ};
    assign pcSeq    = pcCurQ + PC_W'(1);
    assign pcTarget = pcSeq + immExt;

    // NOTE: the latched branch operands are only read after a capture, so they carry
    // no reset; only architecturally visible state is cleared by reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            brTypeQ <= br_type;
            pcCurQ  <= pc_cur;
            brImmQ  <= br_imm;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            pc_write  <= 1'b0;
            taken     <= 1'b0;
            overrun   <= 1'b0;
            alu_out   <= '0;
            flags_q   <= '0;
            pc_next   <= '0;
            taken_cnt <= '0;
        end else begin
            state    <= stateNext;
            done     <= 1'b0;
            pc_write <= 1'b0;

            // Includes the done cycle: the FSM is still in EVAL then.
            if (start && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        alu_out <= alu_z;
                        flags_q <= {carry_flag, zero_flag};
                    end
                end
                CAPTURE: begin
                    taken    <= brTaken;
                    pc_next  <= brTaken ? pcTarget : pcSeq;
                    done     <= 1'b1;
                    pc_write <= 1'b1;
                    if (brTaken && taken_cnt != {CNT_W{1'b1}}) begin
                        taken_cnt <= taken_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: vector table plus overrun, reset-abort and
// counter-saturation sequences on a CNT_W=2 instance.
module tb_branch_resolve_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int IMM_W  = 16;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_GT   = 3'b011;
    localparam logic [2:0] BR_LT   = 3'b100;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] alu_z;
    logic              zero_flag;
    logic              carry_flag;
    logic [2:0]        br_type;
    logic [PC_W-1:0]   pc_cur;
    logic [IMM_W-1:0]  br_imm;

    logic              busy, done, taken, pc_write, overrun;
    logic [DATA_W-1:0] alu_out;
    logic [1:0]        flags_q;
    logic [PC_W-1:0]   pc_next;
    logic [15:0]       taken_cnt;

    logic              sBusy, sDone, sTaken, sPcWrite, sOverrun;
    logic [DATA_W-1:0] sAluOut;
    logic [1:0]        sFlags;
    logic [PC_W-1:0]   sPcNext;
    logic [1:0]        sTakenCnt;

    always #5 clk = ~clk;

    branch_resolve_stage dut (
        .clk(clk), .reset(reset), .start(start), .alu_z(alu_z),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .br_type(br_type),
        .pc_cur(pc_cur), .br_imm(br_imm), .busy(busy), .done(done),
        .alu_out(alu_out), .flags_q(flags_q), .taken(taken), .pc_next(pc_next),
        .pc_write(pc_write), .taken_cnt(taken_cnt), .overrun(overrun)
    );

    branch_resolve_stage #(.CNT_W(2)) dutSat (
        .clk(clk), .reset(reset), .start(start), .alu_z(alu_z),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .br_type(br_type),
        .pc_cur(pc_cur), .br_imm(br_imm), .busy(sBusy), .done(sDone),
        .alu_out(sAluOut), .flags_q(sFlags), .taken(sTaken), .pc_next(sPcNext),
        .pc_write(sPcWrite), .taken_cnt(sTakenCnt), .overrun(sOverrun)
    );

    typedef struct {
        logic [31:0] z;
        logic        zf;
        logic        cf;
        logic [2:0]  bt;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        expTaken;
        logic [31:0] expPc;
    } vecT;

    int checks = 0;
    int errors = 0;
    int expCnt = 0;
    int expCntSat = 0;
    int donePulses = 0;

    always @(negedge clk) begin
        if (done) donePulses++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
        expCnt = 0;
        expCntSat = 0;
    endtask

    task automatic runVec(input vecT v, input string tag);
        alu_z = v.z; zero_flag = v.zf; carry_flag = v.cf;
        br_type = v.bt; pc_cur = v.pc; br_imm = v.imm;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " alu_out n+1"}, 64'(alu_out), 64'(v.z));
        check({tag, " flags_q n+1"}, 64'(flags_q), 64'({v.cf, v.zf}));
        check({tag, " busy n+1"}, 64'(busy), 64'd1);
        check({tag, " done n+1"}, 64'(done), 64'd0);
        tick();
        if (v.expTaken) begin
            if (expCnt < 65535) expCnt++;
            if (expCntSat < 3) expCntSat++;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " pc_write"}, 64'(pc_write), 64'd1);
        check({tag, " taken"}, 64'(taken), 64'(v.expTaken));
        check({tag, " pc_next"}, 64'(pc_next), 64'(v.expPc));
        check({tag, " taken_cnt"}, 64'(taken_cnt), 64'(expCnt));
        check({tag, " taken_cnt sat"}, 64'(sTakenCnt), 64'(expCntSat));
        tick();
        check({tag, " done low"}, 64'(done), 64'd0);
        check({tag, " pc_write low"}, 64'(pc_write), 64'd0);
        check({tag, " busy low"}, 64'(busy), 64'd0);
        check({tag, " pc_next held"}, 64'(pc_next), 64'(v.expPc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecT vecs[12];
        vecT v;
        logic [1:0] satExp[5];
        int pulsesBefore;

        vecs[0]  = '{32'h0000_0000, 1'b1, 1'b0, BR_EQ,   32'h0000_0010, 16'h0004, 1'b1, 32'h0000_0015};
        vecs[1]  = '{32'h8000_0000, 1'b0, 1'b1, BR_LT,   32'h0000_0020, 16'hFFFE, 1'b0, 32'h0000_0021};
        vecs[2]  = '{32'h0000_1234, 1'b0, 1'b0, BR_LT,   32'h0000_0020, 16'hFFFE, 1'b1, 32'h0000_001F};
        vecs[3]  = '{32'h0000_0000, 1'b1, 1'b0, BR_NONE, 32'hFFFF_FFFF, 16'h0005, 1'b0, 32'h0000_0000};
        vecs[4]  = '{32'h0000_0000, 1'b1, 1'b0, BR_NE,   32'h0000_0100, 16'h0010, 1'b0, 32'h0000_0101};
        vecs[5]  = '{32'h0000_0005, 1'b0, 1'b0, BR_NE,   32'h0000_0100, 16'h0010, 1'b1, 32'h0000_0111};
        vecs[6]  = '{32'h8000_0001, 1'b0, 1'b1, BR_GT,   32'h0000_0040, 16'h0008, 1'b1, 32'h0000_0049};
        vecs[7]  = '{32'h0000_0007, 1'b0, 1'b0, BR_GT,   32'h0000_0040, 16'h0008, 1'b0, 32'h0000_0041};
        vecs[8]  = '{32'h0000_0007, 1'b0, 1'b0, BR_EQ,   32'h0000_0040, 16'h0008, 1'b0, 32'h0000_0041};
        vecs[9]  = '{32'h0000_0000, 1'b1, 1'b0, 3'b101,  32'h0000_0040, 16'h0008, 1'b0, 32'h0000_0041};
        vecs[10] = '{32'h0000_0000, 1'b1, 1'b0, BR_LT,   32'h0000_0040, 16'h0008, 1'b0, 32'h0000_0041};
        vecs[11] = '{32'h0000_0000, 1'b1, 1'b0, BR_EQ,   32'hFFFF_FFF0, 16'h0020, 1'b1, 32'h0000_0011};
        satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        reset = 1'b1; start = 1'b0; alu_z = '0; zero_flag = 1'b0; carry_flag = 1'b0;
        br_type = BR_NONE; pc_cur = '0; br_imm = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset pc_write", 64'(pc_write), 64'd0);
        check("reset taken", 64'(taken), 64'd0);
        check("reset overrun", 64'(overrun), 64'd0);
        check("reset alu_out", 64'(alu_out), 64'd0);
        check("reset flags_q", 64'(flags_q), 64'd0);
        check("reset pc_next", 64'(pc_next), 64'd0);
        check("reset taken_cnt", 64'(taken_cnt), 64'd0);

        for (int i = 0; i < 12; i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end
        check("table overrun clear", 64'(overrun), 64'd0);

        // Second start one cycle after the first: ignored, flagged as overrun.
        doReset();
        pulsesBefore = donePulses;
        alu_z = 32'h0; zero_flag = 1'b1; carry_flag = 1'b0; br_type = BR_EQ;
        pc_cur = 32'h10; br_imm = 16'h0004; start = 1'b1;
        tick();
        alu_z = 32'h0000_DEAD; zero_flag = 1'b0; pc_cur = 32'h500;
        tick();
        start = 1'b0;
        check("ovr1 done", 64'(done), 64'd1);
        check("ovr1 overrun", 64'(overrun), 64'd1);
        check("ovr1 alu_out kept", 64'(alu_out), 64'd0);
        check("ovr1 pc_next", 64'(pc_next), 64'h15);
        for (int i = 0; i < 4; i++) tick();
        check("ovr1 single done", 64'(donePulses - pulsesBefore), 64'd1);
        check("ovr1 idle", 64'(busy), 64'd0);

        // Start during the done cycle is also ignored.
        doReset();
        check("ovr2 overrun cleared", 64'(overrun), 64'd0);
        pulsesBefore = donePulses;
        br_type = BR_NE; zero_flag = 1'b0; alu_z = 32'h3; pc_cur = 32'h30; br_imm = 16'h0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("ovr2 done", 64'(done), 64'd1);
        start = 1'b1; pc_cur = 32'h900;
        tick();
        start = 1'b0;
        check("ovr2 overrun", 64'(overrun), 64'd1);
        check("ovr2 busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        check("ovr2 single done", 64'(donePulses - pulsesBefore), 64'd1);
        check("ovr2 pc_next", 64'(pc_next), 64'h33);

        // Reset one cycle after start aborts the operation.
        pulsesBefore = donePulses;
        alu_z = 32'h0000_0055; zero_flag = 1'b1; br_type = BR_EQ; pc_cur = 32'h60;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort alu_out captured", 64'(alu_out), 64'h55);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expCnt = 0;
        expCntSat = 0;
        check("abort done", 64'(done), 64'd0);
        check("abort pc_write", 64'(pc_write), 64'd0);
        check("abort alu_out", 64'(alu_out), 64'd0);
        check("abort overrun", 64'(overrun), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort pc_next", 64'(pc_next), 64'd0);
        check("abort taken_cnt", 64'(taken_cnt), 64'd0);
        tick();
        tick();
        check("abort no done", 64'(donePulses - pulsesBefore), 64'd0);

        // Five taken BNE back-to-back against the 2-bit counter.
        doReset();
        pulsesBefore = donePulses;
        v = '{32'h0000_0009, 1'b0, 1'b1, BR_NE, 32'h0000_0100, 16'h0001, 1'b1, 32'h0000_0102};
        for (int i = 0; i < 5; i++) begin
            runVec(v, $sformatf("sat%0d", i));
            check($sformatf("sat%0d count", i), 64'(sTakenCnt), 64'(satExp[i]));
        end
        check("sat done pulses", 64'(donePulses - pulsesBefore), 64'd5);
        check("sat wide counter", 64'(taken_cnt), 64'd5);
        check("sat overrun", 64'(overrun), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
